// File: rtl/timer_mc_core.sv
// timer_mc_core: multi-channel timer with one shared prescaler. Each channel
// counts up or down in repeat or one-shot mode, can cascade from the channel
// below it, and drives a PWM level from its counter.
//
// Optional feature macro: TIMER_MC_CAPTURE_EN
//   defined   -> a rising capture_i[i] latches the counter into cap_val and
//                pulses cap_stb
//   undefined -> cap_val and cap_stb are tied to 0 and capture_i is unused
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   pre_en, pre_val       prescaler enable and reload value
//   pre_load              force a prescaler reload (no tick that cycle)
//   en, mode, dir         per channel: enable, repeat(1)/one-shot(0), up(1)/down(0)
//   pwm_en, ext_en, chain per channel: PWM enable, external tick, cascade
//   load_cmd              per channel force load
//   load_val, cmp_val     per-channel period and compare, channel i at [i*CNT_W +: CNT_W]
//   ext_i, capture_i      per-channel external count and capture inputs
//   cnt_val, cap_val      current and captured counters
//   irq_o, trig_o         one-cycle pulses, the cycle after an expire event
//   pwm_o                 PWM level (combinational from the counter register)
//   cap_stb               capture strobe
module timer_mc_core #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pre_en,
  input  logic [PRE_W-1:0]        pre_val,
  input  logic                    pre_load,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       pwm_en,
  input  logic [NUM_CH-1:0]       ext_en,
  input  logic [NUM_CH-1:0]       chain,
  input  logic [NUM_CH-1:0]       load_cmd,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  input  logic [NUM_CH*CNT_W-1:0] cmp_val,
  input  logic [NUM_CH-1:0]       ext_i,
  input  logic [NUM_CH-1:0]       capture_i,
  output logic [NUM_CH*CNT_W-1:0] cnt_val,
  output logic [NUM_CH*CNT_W-1:0] cap_val,
  output logic [NUM_CH-1:0]       irq_o,
  output logic [NUM_CH-1:0]       trig_o,
  output logic [NUM_CH-1:0]       pwm_o,
  output logic [NUM_CH-1:0]       cap_stb
);

  logic [PRE_W-1:0]  pre_cnt;
  logic              pre_run;
  logic              pre_tick;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] at_term;
  logic [NUM_CH-1:0] done_v;
  logic [NUM_CH-1:0] ext_rise;

  // Shared prescaler: runs only while some enabled channel uses it.
  assign pre_run  = |(en & ~ext_en);
  assign pre_tick = !pre_load && (!pre_en || (pre_run && (pre_cnt == '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_load) begin
      pre_cnt <= pre_val;
    end else if (pre_en && pre_run) begin
      if (pre_cnt == '0) pre_cnt <= pre_val;
      else               pre_cnt <= pre_cnt - PRE_W'(1);
    end
  end

  // Tick selection and expire events. A chained channel sees the expire of
  // the channel below it in the same cycle, so the chain ripples in order.
  always_comb begin
    logic prev_exp;
    tick     = '0;
    expire   = '0;
    prev_exp = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (i != 0 && chain[i]) tick[i] = prev_exp;
      else if (ext_en[i])     tick[i] = ext_rise[i];
      else                    tick[i] = pre_tick;
      expire[i] = en[i] & ~load_cmd[i] & ~done_v[i] & tick[i] & at_term[i];
      prev_exp  = expire[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] lv;
    logic [CNT_W-1:0] cmp;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             irq;
    logic             ext_q;

    assign lv  = load_val[g*CNT_W +: CNT_W];
    assign cmp = cmp_val[g*CNT_W +: CNT_W];

    assign at_term[g]  = dir[g] ? (cnt == lv) : (cnt == '0);
    assign done_v[g]   = done;
    assign ext_rise[g] = ext_i[g] & ~ext_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt   <= '0;
        done  <= 1'b0;
        irq   <= 1'b0;
        ext_q <= 1'b0;
      end else begin
        ext_q <= ext_i[g];
        irq   <= expire[g];
        if (!en[g]) begin
          done <= 1'b0;
        end else if (load_cmd[g]) begin
          cnt  <= dir[g] ? '0 : lv;
          done <= 1'b0;
        end else if (tick[g] && !done) begin
          if (at_term[g]) begin
            if (mode[g]) begin
              cnt <= dir[g] ? '0 : lv;
            end else begin
              cnt  <= dir[g] ? lv : '0;
              done <= 1'b1;
            end
          end else begin
            cnt <= dir[g] ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
          end
        end
      end
    end

    assign cnt_val[g*CNT_W +: CNT_W] = cnt;
    assign irq_o[g]  = irq;
    assign trig_o[g] = irq;
    assign pwm_o[g]  = pwm_en[g] & (dir[g] ? (cnt < cmp) : (cnt <= cmp));

`ifdef TIMER_MC_CAPTURE_EN
    logic             cap_q;
    logic             stb;
    logic [CNT_W-1:0] cap;

    always_ff @(posedge clk) begin
      if (rst) begin
        cap_q <= 1'b0;
        stb   <= 1'b0;
        cap   <= '0;
      end else begin
        cap_q <= capture_i[g];
        stb   <= capture_i[g] & ~cap_q;
        if (capture_i[g] && !cap_q) cap <= cnt;
      end
    end

    assign cap_val[g*CNT_W +: CNT_W] = cap;
    assign cap_stb[g] = stb;
`else
    assign cap_val[g*CNT_W +: CNT_W] = '0;
    assign cap_stb[g] = 1'b0;
`endif
  end

`ifndef TIMER_MC_CAPTURE_EN
  logic unused_capture;
  assign unused_capture = ^capture_i;
`endif

endmodule

// File: tb/tb_timer_mc_core.sv
// Directed testbench for timer_mc_core (NUM_CH=4, CNT_W=32, PRE_W=16).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_timer_mc_core;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int PRE_W  = 16;

  logic                    clk;
  logic                    rst;
  logic                    pre_en;
  logic [PRE_W-1:0]        pre_val;
  logic                    pre_load;
  logic [NUM_CH-1:0]       en, mode, dir, pwm_en, ext_en, chain, load_cmd;
  logic [NUM_CH*CNT_W-1:0] load_val, cmp_val;
  logic [NUM_CH-1:0]       ext_i, capture_i;
  logic [NUM_CH*CNT_W-1:0] cnt_val, cap_val;
  logic [NUM_CH-1:0]       irq_o, trig_o, pwm_o, cap_stb;

  int n_checks = 0;
  int n_fail   = 0;

  timer_mc_core #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .pre_en(pre_en), .pre_val(pre_val), .pre_load(pre_load),
    .en(en), .mode(mode), .dir(dir), .pwm_en(pwm_en), .ext_en(ext_en), .chain(chain),
    .load_cmd(load_cmd), .load_val(load_val), .cmp_val(cmp_val), .ext_i(ext_i),
    .capture_i(capture_i), .cnt_val(cnt_val), .cap_val(cap_val), .irq_o(irq_o),
    .trig_o(trig_o), .pwm_o(pwm_o), .cap_stb(cap_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lv(input int ch, input logic [CNT_W-1:0] v);
    load_val[ch*CNT_W +: CNT_W] = v;
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return cnt_val[ch*CNT_W +: CNT_W];
  endfunction

  int          c0_cnt [8]  = '{2, 1, 0, 3, 2, 1, 0, 3};
  logic        c0_irq [8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
  int          c1_cnt [6]  = '{1, 2, 3, 4, 5, 5};
  logic        c1_irq [6]  = '{0, 0, 0, 0, 0, 1};
  int          pr_cnt [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  logic        pr_irq [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int          ch_cnt [9]  = '{2, 2, 1, 1, 1, 0, 0, 0, 2};
  logic        ch_irq [9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
  logic [127:0] exp_cap;

  initial begin
    rst = 1'b1; pre_en = 1'b0; pre_val = '0; pre_load = 1'b0;
    en = '0; mode = '0; dir = '0; pwm_en = 4'b0001; ext_en = '0; chain = '0;
    load_cmd = '0; load_val = '0; cmp_val = '0; ext_i = '0; capture_i = '0;
    step(2);
    // Reset state; pwm on ch0 with cnt=0 <= cmp=0 (down) is high.
    check("rst_cnt", cnt_val, '0);
    check("rst_irq", irq_o, '0);
    check("rst_trig", trig_o, '0);
    check("rst_pwm", pwm_o, 4'b0001);
    check("rst_cap", cap_val, '0);
    check("rst_stb", cap_stb, '0);
    rst = 1'b0; pwm_en = '0;

    // ch0 down, repeat, load 3, prescaler off: period 4.
    dir[0] = 1'b0; mode[0] = 1'b1; set_lv(0, 3); en[0] = 1'b1; load_cmd[0] = 1'b1;
    step(1);
    check("c0_load", cnt_of(0), 3);
    check("c0_load_irq", irq_o[0], 1'b0);
    load_cmd[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check($sformatf("c0_cnt%0d", k), cnt_of(0), c0_cnt[k]);
      check($sformatf("c0_irq%0d", k), irq_o[0], c0_irq[k]);
      check($sformatf("c0_trig%0d", k), trig_o[0], c0_irq[k]);
    end
    en[0] = 1'b0;
    step(1);
    check("c0_freeze", cnt_of(0), 3);
    check("c0_freeze_irq", irq_o[0], 1'b0);

    // ch1 up, one-shot, load 5, PWM compare 3.
    dir[1] = 1'b1; mode[1] = 1'b0; set_lv(1, 5); cmp_val[CNT_W +: CNT_W] = 3;
    pwm_en[1] = 1'b1; en[1] = 1'b1; load_cmd[1] = 1'b1;
    step(1);
    load_cmd[1] = 1'b0;
    check("c1_load", cnt_of(1), 0);
    check("c1_pwm_lo_cnt", pwm_o[1], 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1);
      check($sformatf("c1_cnt%0d", k), cnt_of(1), c1_cnt[k]);
      check($sformatf("c1_irq%0d", k), irq_o[1], c1_irq[k]);
    end
    for (int k = 0; k < 4; k++) begin
      step(1);
      check($sformatf("c1_hold%0d", k), cnt_of(1), 5);
      check($sformatf("c1_noirq%0d", k), irq_o[1], 1'b0);
    end
    check("c1_pwm_hi_cnt", pwm_o[1], 1'b0);
    load_cmd[1] = 1'b1;
    step(1);
    load_cmd[1] = 1'b0;
    check("c1_reload", cnt_of(1), 0);
    check("c1_reload_irq", irq_o[1], 1'b0);
    step(1);
    check("c1_restart", cnt_of(1), 1);
    en[1] = 1'b0; pwm_en[1] = 1'b0;

    // Prescaler reload 2 -> tick every 3 clocks; ch0 down load 1.
    pre_en = 1'b1; pre_val = 2; pre_load = 1'b1;
    set_lv(0, 1); dir[0] = 1'b0; mode[0] = 1'b1; en[0] = 1'b1; load_cmd[0] = 1'b1;
    step(1);
    pre_load = 1'b0; load_cmd[0] = 1'b0;
    check("pr_load", cnt_of(0), 1);
    for (int k = 0; k < 12; k++) begin
      step(1);
      check($sformatf("pr_cnt%0d", k), cnt_of(0), pr_cnt[k]);
      check($sformatf("pr_irq%0d", k), irq_o[0], pr_irq[k]);
    end
    pre_en = 1'b0; en[0] = 1'b0;

    // Cascade: ch1 ticks only on ch0 expire.
    set_lv(0, 2); set_lv(1, 2); dir[1:0] = 2'b00; mode[1:0] = 2'b11;
    chain[1] = 1'b1; en[1:0] = 2'b11; load_cmd[1:0] = 2'b11;
    step(1);
    load_cmd[1:0] = 2'b00;
    check("ch_load", cnt_of(1), 2);
    for (int k = 0; k < 9; k++) begin
      step(1);
      check($sformatf("ch_cnt%0d", k), cnt_of(1), ch_cnt[k]);
      check($sformatf("ch_irq%0d", k), irq_o[1], ch_irq[k]);
    end
    chain = '0; en = '0;

    // External tick on ch3: one decrement per rising edge of ext_i[3].
    set_lv(3, 5); dir[3] = 1'b0; mode[3] = 1'b1; ext_en[3] = 1'b1; en[3] = 1'b1;
    load_cmd[3] = 1'b1;
    step(1);
    load_cmd[3] = 1'b0;
    check("ext_load", cnt_of(3), 5);
    ext_i[3] = 1'b1; step(1); check("ext_rise1", cnt_of(3), 4);
    step(1);                  check("ext_high", cnt_of(3), 4);
    ext_i[3] = 1'b0; step(1); check("ext_fall", cnt_of(3), 4);
    ext_i[3] = 1'b1; step(1); check("ext_rise2", cnt_of(3), 3);
    en[3] = 1'b0; ext_en[3] = 1'b0; ext_i[3] = 1'b0;

    // load_cmd coincident with expire on ch2, then reset on an expire cycle.
    set_lv(2, 2); dir[2] = 1'b0; mode[2] = 1'b1; en[2] = 1'b1; load_cmd[2] = 1'b1;
    step(1);
    load_cmd[2] = 1'b0;
    step(2);
    check("c2_zero", cnt_of(2), 0);
    load_cmd[2] = 1'b1;
    step(1);
    load_cmd[2] = 1'b0;
    check("c2_ldexp_cnt", cnt_of(2), 2);
    check("c2_ldexp_irq", irq_o[2], 1'b0);
    check("c2_ldexp_trig", trig_o[2], 1'b0);
    step(2);
    check("c2_zero2", cnt_of(2), 0);
    rst = 1'b1;
    step(1);
    check("mid_rst_cnt", cnt_val, '0);
    check("mid_rst_irq", irq_o, '0);
    check("mid_rst_trig", trig_o, '0);
    check("mid_rst_pwm", pwm_o, '0);
    check("mid_rst_stb", cap_stb, '0);
    rst = 1'b0; en = '0;

    // Capture on ch3 at cnt=7.
    exp_cap = '0;
`ifdef TIMER_MC_CAPTURE_EN
    exp_cap[3*CNT_W +: CNT_W] = 7;
`endif
    set_lv(3, 9); dir[3] = 1'b0; mode[3] = 1'b1; en[3] = 1'b1; load_cmd[3] = 1'b1;
    step(1);
    load_cmd[3] = 1'b0;
    step(2);
    check("cap_pre", cnt_of(3), 7);
    capture_i[3] = 1'b1;
    step(1);
    check("cap_cnt_after", cnt_of(3), 6);
    check("cap_val", cap_val, exp_cap);
`ifdef TIMER_MC_CAPTURE_EN
    check("cap_stb_hi", cap_stb, 4'b1000);
`else
    check("cap_stb_hi", cap_stb, 4'b0000);
`endif
    step(1);
    check("cap_stb_lo", cap_stb, 4'b0000);
    check("cap_val_hold", cap_val, exp_cap);
    capture_i = '0; en = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_mc_core.md
TIMER_MC_CORE -- requirements
Module: timer_mc_core

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the counter width per channel (8..32).
REQ-003 SHALL have parameter PRE_W, default 16, meaning the shared prescaler width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock (all logic on posedge).
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 pre_en  in  1  shared prescaler enable; pre_val  in  PRE_W  prescaler reload; pre_load  in  1  force prescaler reload.
REQ-007 en, mode, dir, pwm_en, ext_en, chain, load_cmd  in  NUM_CH each  per-channel enable, repeat(1)/one-shot(0), up(1)/down(0), PWM enable, external tick select, cascade select, force load.
REQ-008 load_val, cmp_val  in  NUM_CH*CNT_W  per-channel period and compare (channel i at [i*CNT_W +: CNT_W]).
REQ-009 ext_i, capture_i  in  NUM_CH  per-channel external count and capture inputs.
REQ-010 cnt_val, cap_val  out  NUM_CH*CNT_W  current counter, captured counter.
REQ-011 irq_o, trig_o, pwm_o, cap_stb  out  NUM_CH  expire IRQ pulse, trigger pulse, PWM level, capture strobe.

Function
REQ-012 Prescaler SHALL count down from pre_val and assert a one-cycle pre_tick when it reaches 0 (then reload); pre_tick asserted every cycle when pre_en=0; pre_load reloads pre_val with no pre_tick that cycle.
REQ-013 Prescaler SHALL run only while any channel has en=1 and ext_en=0.
REQ-014 Channel i tick SHALL be: chain[i]=1 and i>0 -> expire event of channel i-1 in the same cycle; else ext_en[i]=1 -> rising edge of ext_i[i] (one-register edge detect); else pre_tick. chain[0] SHALL be ignored.
REQ-015 Down count: on tick, cnt!=0 -> cnt-1; cnt==0 -> expire event, repeat reloads load_val, one-shot holds 0.
REQ-016 Up count: on tick, cnt!=load_val -> cnt+1; cnt==load_val -> expire event, repeat reloads 0, one-shot holds load_val.
REQ-017 Expire event SHALL produce irq_o[i] and trig_o[i] high for exactly one cycle, the cycle after the event.
REQ-018 One-shot SHALL set a per-channel done flag on expire; while done, ticks are ignored; done cleared by load_cmd[i] or en[i]=0.
REQ-019 load_cmd[i] SHALL load load_val (dir=0) or 0 (dir=1), clear done, suppress irq/trig that cycle, and take priority over a coincident tick.
REQ-020 en[i]=0 SHALL freeze cnt_val and force irq_o/trig_o low.
REQ-021 pwm_o[i] SHALL be 0 when pwm_en[i]=0; else (cnt <= cmp_val) for down, (cnt < cmp_val) for up; combinational from the counter register.
REQ-022 Capture: rising edge of capture_i[i] SHALL latch the pre-update counter into cap_val[i] and pulse cap_stb[i] one cycle later, independent of en.
REQ-023 Channels SHALL be independent except via prescaler sharing and chain.

Reset
REQ-024 While rst=1 at a clk edge: counters, cap_val, prescaler, done flags, edge registers to 0; irq_o, trig_o, cap_stb to 0; pwm_o follows REQ-021 with cnt=0.
REQ-025 Reset mid-count SHALL abort all channels with no irq/trig pulse on the following cycle.

Configuration
REQ-026 Macro TIMER_MC_CAPTURE_EN: defined -> capture logic per REQ-022; undefined -> no capture registers, cap_val tied 0, cap_stb tied 0, capture_i unused.

Verification
REQ-027 NUM_CH=4, ch0 down repeat, load_val=3, pre_en=0 -> irq_o[0] pulses every 4 cycles, cnt_val 3,2,1,0,3.
REQ-028 ch1 up one-shot load_val=5 -> single irq_o[1] pulse, cnt holds 5, no further pulses until load_cmd[1].
REQ-029 pre_en=1 pre_val=2, ch0 down load_val=1 -> count decrements every 3 clocks, irq every 6.
REQ-030 ch0 repeat load_val=0xFFFFFFFF with wrap driven, ch1 chain=1 load_val=2 -> ch1 decrements only on ch0 expire cycles.
REQ-031 load_cmd[2] coincident with ch2 expire -> counter = load_val, no irq_o[2] pulse; rst asserted mid-count -> all outputs 0 next cycle.
REQ-032 With TIMER_MC_CAPTURE_EN, capture_i[3] rising at cnt=7 -> cap_val[3]=7, cap_stb[3] one-cycle pulse; without macro -> cap_val=0, cap_stb=0.
